trap_seq: RTL



---
 rtl/trap_seq_if.sv | 38 +++
 rtl/trap_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/trap_seq_if.sv
// ---------------------------------------------------------------------------
// trap_seq_if
//   Commit bus between the trap sequencer and its consumers: the Machine-mode
//   CSR side-effect strobes/data going to the CSR file, and the fetch
//   redirect valid/ready handshake.
//
//   master : the trap sequencer (drives strobes, data and redir_valid/pc)
//   slave  : CSR file + fetch unit (drives redir_ready)
// ---------------------------------------------------------------------------
interface trap_seq_if #(
    parameter int PC_SZ = 32,
    parameter int RSZ   = 32
);
    logic             mepc_we;
    logic [PC_SZ-1:0] mepc_wd;
    logic             mcause_we;
    logic [RSZ-1:0]   mcause_wd;
    logic             mtval_we;
    logic [RSZ-1:0]   mtval_wd;
    logic             mstatus_trap;
    logic [1:0]       mpp_wd;
    logic             mstatus_mret;
    logic             redir_valid;
    logic [PC_SZ-1:0] redir_pc;
    logic             redir_ready;

    modport master (
        output mepc_we, mepc_wd, mcause_we, mcause_wd, mtval_we, mtval_wd,
               mstatus_trap, mpp_wd, mstatus_mret, redir_valid, redir_pc,
        input  redir_ready
    );

    modport slave (
        input  mepc_we, mepc_wd, mcause_we, mcause_wd, mtval_we, mtval_wd,
               mstatus_trap, mpp_wd, mstatus_mret, redir_valid, redir_pc,
        output redir_ready
    );
endinterface

// File: rtl/trap_seq.sv
// ---------------------------------------------------------------------------
// trap_seq
//   Trap commit sequencer in the WB stage. Detects an exception, interrupt or
//   MRET on the retiring instruction, drains the pipeline, issues the
//   Machine-mode CSR side effects in a single cycle and then redirects fetch
//   to the handler (trap) or to mepc (MRET) through a valid/ready handshake.
//
//   Ports:
//     clk_in, reset_in       clock, asynchronous active-low reset
//     wb_valid, wb_pc        retiring instruction and its PC
//     exception_*            synchronous exception flag / code / trap value
//     interrupt_*            interrupt request (level) / code
//     mret                   WB instruction is MRET
//     trap_pc, mode, mepc_in handler address, current mode, current mepc
//     pipe_empty             upstream stages are empty after the flush
//     retire_kill            suppress retirement of the WB instruction
//     flush                  squash IF..MEM
//     busy                   sequencer is not idle
//     cmt                    CSR write strobes + fetch redirect handshake
// ---------------------------------------------------------------------------
module trap_seq #(
    parameter int PC_SZ = 32,
    parameter int RSZ   = 32
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             wb_valid,
    input  logic [PC_SZ-1:0] wb_pc,
    input  logic             exception_flag,
    input  logic [3:0]       exception_cause,
    input  logic [RSZ-1:0]   exception_tval,
    input  logic             interrupt_flag,
    input  logic [3:0]       interrupt_cause,
    input  logic             mret,
    input  logic [PC_SZ-1:0] trap_pc,
    input  logic [1:0]       mode,
    input  logic [PC_SZ-1:0] mepc_in,
    input  logic             pipe_empty,
    output logic             retire_kill,
    output logic             flush,
    output logic             busy,
    trap_seq_if.master       cmt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_CSR_WR   = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [1:0] T_EXC = 2'd0;
    localparam logic [1:0] T_IRQ = 2'd1;
    localparam logic [1:0] T_RET = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [PC_SZ-1:0] pc_q, pc_d;
    logic [4:0]       cause_q, cause_d;
    logic [RSZ-1:0]   tval_q, tval_d;
    logic [PC_SZ-1:0] tgt_q, tgt_d;
    logic [1:0]       mode_q;

    logic in_idle;
    logic take_event;
    logic csr_cycle;
    logic csr_trap;

    assign in_idle    = (state_q == S_IDLE);
    // Flags are only meaningful alongside a valid WB instruction, and only
    // while idle; anything arriving mid-sequence is dropped.
    assign take_event = in_idle & wb_valid & (exception_flag | interrupt_flag | mret);

    // Event classification and capture values, fixed priority EXC > IRQ > RET.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        type_d  = T_RET;
        pc_d    = mepc_in;
        cause_d = '0;
        tval_d  = '0;
        tgt_d   = mepc_in;
        if (exception_flag) begin
            type_d  = T_EXC;
            pc_d    = wb_pc;
            cause_d = {1'b0, exception_cause};
            tval_d  = exception_tval;
            tgt_d   = trap_pc;
        end else if (interrupt_flag) begin
            type_d  = T_IRQ;
            pc_d    = wb_pc;
            cause_d = {1'b1, interrupt_cause};
            tgt_d   = trap_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (take_event)      state_d = S_FLUSH;
            S_FLUSH:    if (pipe_empty)      state_d = S_CSR_WR;
            S_CSR_WR:                        state_d = S_REDIRECT;
            S_REDIRECT: if (cmt.redir_ready) state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // Capture registers are reset too (not just the state) so no stale
    // CSR data can ever appear on the bus after reset.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
            type_q  <= T_EXC;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            tgt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_event) begin
                type_q  <= type_d;
                pc_q    <= pc_d;
                cause_q <= cause_d;
                tval_q  <= tval_d;
                tgt_q   <= tgt_d;
                mode_q  <= mode;
            end
        end
    end

    // All outputs decode from registered state, so the asynchronous reset
    // drops them immediately. retire_kill is the only path from inputs; it
    // is gated by reset so it too is low while reset is held.
    assign retire_kill = reset_in & in_idle & wb_valid & (exception_flag | interrupt_flag);
    assign flush       = (state_q == S_FLUSH);
    assign busy        = !in_idle;

    assign csr_cycle = (state_q == S_CSR_WR);
    assign csr_trap  = csr_cycle & (type_q != T_RET);

    assign cmt.mepc_we      = csr_trap;
    assign cmt.mepc_wd      = csr_trap ? {pc_q[PC_SZ-1:2], 2'b00} : '0;
    assign cmt.mcause_we    = csr_trap;
    assign cmt.mcause_wd    = csr_trap ? {cause_q[4], {(RSZ-5){1'b0}}, cause_q[3:0]} : '0;
    assign cmt.mtval_we     = csr_trap;
    assign cmt.mtval_wd     = csr_trap ? tval_q : '0;
    assign cmt.mstatus_trap = csr_trap;
    assign cmt.mpp_wd       = csr_trap ? mode_q : 2'b00;
    assign cmt.mstatus_mret = csr_cycle & (type_q == T_RET);

    assign cmt.redir_valid  = (state_q == S_REDIRECT);
    assign cmt.redir_pc     = cmt.redir_valid ? tgt_q : '0;

endmodule
